// File: rtl/sv_palette_mapper.sv
// 2-bit pixel to RGB888 colour stage with a downloadable palette.
// A user palette is staged in a shadow bank and goes live at vblank.
module sv_palette_mapper #(
  parameter int          PAL_BYTES = 12,
  parameter logic [23:0] DEF_PAL0  = 24'h87BA6B,
  parameter logic [23:0] DEF_PAL1  = 24'h6BA378,
  parameter logic [23:0] DEF_PAL2  = 24'h386B82,
  parameter logic [23:0] DEF_PAL3  = 24'h384052
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pal_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  input  logic       custom_en,
  input  logic       blend_en,
  input  logic       ce_pix,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [1:0] pixel,
  input  logic [1:0] prev_pixel,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       pal_valid,
  output logic       pal_err
);

  localparam logic [3:0] PB = 4'(PAL_BYTES);
  localparam logic [23:0] DEF [4] = '{DEF_PAL0, DEF_PAL1, DEF_PAL2, DEF_PAL3};

  logic        dl_q, vb_q;
  logic        dl_rise, dl_fall, vb_rise;
  logic        pending_q, pending_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d, cnt_b;
  logic [1:0]  col_q, col_d, col_b;
  logic [1:0]  comp_q, comp_d, comp_b;
  logic [23:0] shadow_q [4];
  logic [23:0] shadow_d [4];
  logic [23:0] active_q [4];
  logic [23:0] active_d [4];
  logic [23:0] sel [4];
  logic [23:0] cur, prv;
  logic [23:0] rgb_q, rgb_d;

  assign dl_rise = pal_download & ~dl_q;
  assign dl_fall = ~pal_download & dl_q;
  assign vb_rise = vblank & ~vb_q;

  // a starting download restarts the nested byte counter this same cycle
  assign cnt_b  = dl_rise ? 4'd0 : cnt_q;
  assign col_b  = dl_rise ? 2'd0 : col_q;
  assign comp_b = dl_rise ? 2'd0 : comp_q;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    err_d     = err_q;
    cnt_d     = cnt_b;
    col_d     = col_b;
    comp_d    = comp_b;
    shadow_d  = shadow_q;
    active_d  = active_q;
    if (dl_rise) begin
      pending_d = 1'b0;
      err_d     = 1'b0;
    end
    if (pal_download && ioctl_wr && cnt_b < PB) begin
      case (comp_b)
        2'd0:    shadow_d[col_b][23:16] = ioctl_dout;
        2'd1:    shadow_d[col_b][15:8]  = ioctl_dout;
        default: shadow_d[col_b][7:0]   = ioctl_dout;
      endcase
      cnt_d = cnt_b + 4'd1;
      if (comp_b == 2'd2) begin
        comp_d = 2'd0;
        col_d  = col_b + 2'd1;
      end else begin
        comp_d = comp_b + 2'd1;
      end
    end
    if (dl_fall) begin
      if (cnt_q == PB) pending_d = 1'b1;
      else             err_d     = 1'b1;
    end
    if (pending_q && vb_rise && !dl_rise) begin
      active_d  = shadow_q;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      sel[i] = (custom_en && valid_q) ? active_q[i] : DEF[i];
    cur   = sel[pixel];
    prv   = sel[prev_pixel];
    rgb_d = rgb_q;
    if (ce_pix) begin
      if (hblank || vblank)
        rgb_d = 24'h0;
      else if (blend_en)
        rgb_d = {avg(cur[23:16], prv[23:16]),
                 avg(cur[15:8],  prv[15:8]),
                 avg(cur[7:0],   prv[7:0])};
      else
        rgb_d = cur;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      vb_q      <= 1'b0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      col_q     <= 2'd0;
      comp_q    <= 2'd0;
      shadow_q  <= DEF;
      active_q  <= DEF;
      rgb_q     <= 24'h0;
    end else begin
      dl_q      <= pal_download;
      vb_q      <= vblank;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      comp_q    <= comp_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rgb_q     <= rgb_d;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign pal_valid = valid_q;
  assign pal_err   = err_q;

endmodule
